// File: rtl/pulse_train_pkg.sv
// Shared constants for the pulse train generator: FSM state encoding and parameter defaults.
package pulse_train_pkg;

  localparam int PTG_CNT_W         = 8;
  localparam int PTG_DEFAULT_WIDTH = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/rise_detect.sv
// Registered 0->1 detector: the history flop is registered, so the strobe is valid at the edge that samples the new 1.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic prev;

  // NOTE: the history clears asynchronously, so a level held high through reset reads as a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= sig;
  end

  assign rise = sig & ~prev;

endmodule

// File: rtl/pulse_train_generator.sv
// Pulse train generator: on a trigger rising edge emits count pulses of width cycles separated by gap cycles.
// Optional abort input is enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int CNT_W         = PTG_CNT_W,
  parameter int DEFAULT_WIDTH = PTG_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] gap,
  input  logic [CNT_W-1:0] count,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic             abort,
`endif
  output logic             pulse,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] w_lat, g_lat, rem, cnt;
  logic [CNT_W-1:0] w_eff, g_eff;
  logic             start;
  logic             abort_hit;

  rise_detect u_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (trigger),
    .rise  (start)
  );

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Zero gap is promoted to one so adjacent pulses always stay distinct.
  assign w_eff = (width == '0) ? CNT_W'(DEFAULT_WIDTH) : width;
  assign g_eff = (gap   == '0) ? ONE : gap;

  // cnt holds remaining cycles minus one in the current phase, so all-ones widths never wrap.
  // NOTE: every register here uses <= so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pulse <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      w_lat <= '0;
      g_lat <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit && state != ST_IDLE) begin
        state <= ST_IDLE;
        pulse <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && count != '0) begin
              w_lat <= w_eff;
              g_lat <= g_eff;
              rem   <= count;
              cnt   <= w_eff - ONE;
              state <= ST_HIGH;
              pulse <= 1'b1;
              busy  <= 1'b1;
            end
          end
          ST_HIGH: begin
            if (cnt != '0) begin
              cnt <= cnt - ONE;
            end else if (rem == ONE) begin
              state <= ST_IDLE;
              pulse <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rem   <= rem - ONE;
              cnt   <= g_lat - ONE;
              state <= ST_LOW;
              pulse <= 1'b0;
            end
          end
          ST_LOW: begin
            if (cnt != '0) begin
              cnt <= cnt - ONE;
            end else begin
              cnt   <= w_lat - ONE;
              state <= ST_HIGH;
              pulse <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Self-checking bench for pulse_train_generator: directed scenarios plus randomized stimulus against a timeline model.
module tb_pulse_train_generator;

  localparam int CNT_W = 8;
  localparam int DEF_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             trigger;
  logic [CNT_W-1:0] width, gap, count;
`ifdef PULSE_TRAIN_ABORT_EN
  logic             abort;
`endif
  logic             pulse, busy, done;

  int checks   = 0;
  int failures = 0;

  // Model: a train is a timeline; offset t from its start edge decides every output.
  int m_active, m_t, m_w, m_g, m_n, m_total, m_prev;
  int obs_rises, obs_dones, obs_busy;
  logic last_pulse;

  pulse_train_generator #(.CNT_W(CNT_W), .DEFAULT_WIDTH(DEF_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .width   (width),
    .gap     (gap),
    .count   (count),
`ifdef PULSE_TRAIN_ABORT_EN
    .abort   (abort),
`endif
    .pulse   (pulse),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_t = 0; m_prev = 0;
    m_w = 1; m_g = 1; m_n = 0; m_total = 0;
    last_pulse = 1'b0;
  endtask

  task automatic clear_obs();
    obs_rises = 0; obs_dones = 0; obs_busy = 0;
  endtask

  task automatic step();
    int   edge_seen;
    int   ab;
    int   exp_done;
    int   exp_pulse;
    @(posedge clk);
    #1;
    ab = 0;
`ifdef PULSE_TRAIN_ABORT_EN
    ab = int'(abort);
`endif
    exp_done  = 0;
    edge_seen = (trigger == 1'b1 && m_prev == 0) ? 1 : 0;
    m_prev    = int'(trigger);
    if (m_active != 0) begin
      m_t++;
      if (ab != 0 || m_t == m_total) begin
        m_active = 0;
        exp_done = 1;
      end
    end else if (edge_seen != 0 && count != 0) begin
      m_w      = (width == 0) ? DEF_W : int'(width);
      m_g      = (gap == 0) ? 1 : int'(gap);
      m_n      = int'(count);
      m_total  = m_n * m_w + (m_n - 1) * m_g;
      m_t      = 0;
      m_active = 1;
    end
    exp_pulse = (m_active != 0 && (m_t % (m_w + m_g)) < m_w) ? 1 : 0;
    check("pulse", 32'(pulse), 32'(exp_pulse));
    check("busy",  32'(busy),  32'(m_active));
    check("done",  32'(done),  32'(exp_done));
    if (pulse && !last_pulse) obs_rises++;
    if (done) obs_dones++;
    if (busy) obs_busy++;
    last_pulse = pulse;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_pulse", 32'(pulse), 0);
    check("rst_busy",  32'(busy),  0);
    check("rst_done",  32'(done),  0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; trigger = 1'b0; width = '0; gap = '0; count = '0;
`ifdef PULSE_TRAIN_ABORT_EN
    abort = 1'b0;
`endif
    model_reset();
    clear_obs();
    do_reset();
    run(3);

    // Basic train: 3 high, 2 low, 4 pulses; done 18 cycles after start.
    width = 8'd3; gap = 8'd2; count = 8'd4; clear_obs();
    trigger = 1'b1;
    run(22);
    check("basic_rises", 32'(obs_rises), 4);
    check("basic_dones", 32'(obs_dones), 1);
    check("basic_busy",  32'(obs_busy), 18);
    trigger = 1'b0; run(2);

    // Zero width and gap use the defaults.
    width = 8'd0; gap = 8'd0; count = 8'd2; clear_obs();
    trigger = 1'b1; run(12);
    check("dflt_busy",  32'(obs_busy), 7);
    check("dflt_dones", 32'(obs_dones), 1);
    trigger = 1'b0; run(2);

    // Zero count never starts a train.
    count = 8'd0; clear_obs();
    for (int k = 0; k < 4; k++) begin
      trigger = ~trigger;
      run(20);
    end
    check("zero_busy", 32'(obs_busy), 0);
    trigger = 1'b0; run(2);

    // Mid-train edges and input changes are ignored.
    width = 8'd5; gap = 8'd2; count = 8'd3; clear_obs();
    trigger = 1'b1; run(4);
    trigger = 1'b0; width = 8'd1; count = 8'd7; run(2);
    trigger = 1'b1; run(25);
    check("ign_rises", 32'(obs_rises), 3);
    check("ign_dones", 32'(obs_dones), 1);
    check("ign_busy",  32'(obs_busy), 19);
    trigger = 1'b0; run(2);

    // Reset during the second pulse, then a fresh full train.
    width = 8'd2; gap = 8'd2; count = 8'd4;
    trigger = 1'b1; run(5);
    #2 reset = 1'b1;
    #1;
    check("async_pulse", 32'(pulse), 0);
    check("async_busy",  32'(busy),  0);
    model_reset();
    trigger = 1'b0;
    @(posedge clk); #1;
    check("rst_no_done", 32'(done), 0);
    reset = 1'b0;
    run(3);
    clear_obs();
    trigger = 1'b1; run(18);
    check("fresh_rises", 32'(obs_rises), 4);
    check("fresh_dones", 32'(obs_dones), 1);
    trigger = 1'b0; run(2);

    // Trigger held through reset release counts as an edge.
    width = 8'd1; gap = 8'd1; count = 8'd1;
    trigger = 1'b1;
    do_reset();
    run(4);
    trigger = 1'b0; run(2);

    // Boundary values: maximum width/gap, and maximum count.
    width = 8'hFF; gap = 8'hFF; count = 8'd2; clear_obs();
    trigger = 1'b1; run(770);
    check("max_wg_busy", 32'(obs_busy), 765);
    trigger = 1'b0; run(2);
    width = 8'd1; gap = 8'd1; count = 8'hFF; clear_obs();
    trigger = 1'b1; run(515);
    check("max_cnt_rises", 32'(obs_rises), 255);
    check("max_cnt_dones", 32'(obs_dones), 1);
    trigger = 1'b0; run(2);

`ifdef PULSE_TRAIN_ABORT_EN
    // Abort in a gap with a coincident trigger edge: one done, no restart.
    width = 8'd2; gap = 8'd3; count = 8'd3; clear_obs();
    trigger = 1'b1; run(3);
    trigger = 1'b0; run(1);
    trigger = 1'b1; abort = 1'b1; run(1);
    abort = 1'b0; run(10);
    check("abort_dones", 32'(obs_dones), 1);
    check("abort_rises", 32'(obs_rises), 1);
    trigger = 1'b0; run(2);
`endif

    // Randomized stimulus.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) trigger = ~trigger;
      width = CNT_W'($urandom_range(0, 5));
      gap   = CNT_W'($urandom_range(0, 4));
      count = CNT_W'($urandom_range(0, 4));
`ifdef PULSE_TRAIN_ABORT_EN
      abort = ($urandom_range(0, 39) == 0);
`endif
      if (i == 1200) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
